// File: rtl/md_unit_if.sv
// md_unit_if: request/result bundle between the EX stage and the mult/div unit.
//   start  : one-cycle request strobe, qualifies op/A1/A2
//   op     : 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op
//   A1, A2 : forwarded rs / rt operands
//   busy   : multi-cycle operation in flight
//   HI, LO : architectural HI/LO registers
interface md_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A1;
  logic [31:0] A2;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, op, A1, A2,
    input  busy, HI, LO
  );

  modport slave (
    input  start, op, A1, A2,
    output busy, HI, LO
  );
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers.
//   clk     : pipeline clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : md_unit_if slave (start/op/A1/A2 in, busy/HI/LO out)
// The 64-bit result is computed combinationally from the operands present at the
// accepting edge and parked in a pending register; HI/LO are written only when the
// latency counter expires, so the pipeline sees the fixed MULT/DIV latency.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset_n,
  md_unit_if.slave  bus
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [63:0]       pend_q, pend_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;

  // Result datapath.
  logic [63:0] res;
  logic [63:0] sx_a, sx_b;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;

  always_comb begin
    sx_a  = {{32{bus.A1[31]}}, bus.A1};
    sx_b  = {{32{bus.A2[31]}}, bus.A2};
    a_neg = bus.A1[31];
    b_neg = bus.A2[31];
    a_mag = a_neg ? -bus.A1 : bus.A1;
    b_mag = b_neg ? -bus.A2 : bus.A2;
    // Guarded so a zero divisor never produces X; the zero case is overridden below.
    q_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
    r_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
    res   = '0;
    case (bus.op)
      3'd0: res = sx_a * sx_b;  // low 64 bits of sign-extended product are exact
      3'd1: res = {32'b0, bus.A1} * {32'b0, bus.A2};
      3'd2: begin
        if (bus.A2 == '0) begin
          res = {bus.A1, 32'hFFFF_FFFF};
        end else begin
          // Magnitude divide; 0x80000000 / -1 wraps back to 0x80000000 naturally.
          res = {(a_neg ? -r_mag : r_mag), ((a_neg ^ b_neg) ? -q_mag : q_mag)};
        end
      end
      3'd3: begin
        if (bus.A2 == '0) begin
          res = {bus.A1, 32'hFFFF_FFFF};
        end else begin
          res = {bus.A1 % bus.A2, bus.A1 / bus.A2};
        end
      end
      default: res = '0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          case (bus.op)
            3'd0, 3'd1: begin
              pend_d  = res;
              cnt_d   = CntW'(MULT_CYCLES);
              state_d = StRun;
            end
            3'd2, 3'd3: begin
              pend_d  = res;
              cnt_d   = CntW'(DIV_CYCLES);
              state_d = StRun;
            end
            3'd4:    hi_d = bus.A1;
            3'd5:    lo_d = bus.A1;
            default: ;
          endcase
        end
      end
      StRun: begin
        // Requests arriving here are dropped.
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          hi_d    = pend_q[63:32];
          lo_d    = pend_q[31:0];
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit. Stimulus pushes expected
// HI/LO/busy-length into a scoreboard; a monitor pops and compares when busy falls.
module tb_md_unit;
  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  md_unit_if bus ();

  md_unit #(
    .MULT_CYCLES(MultN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned n;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_hi  = '0;
  logic [31:0] m_lo  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: counts busy-high cycles and checks the landed result when busy drops.
  initial begin
    int unsigned bcnt;
    exp_t        e;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        bcnt = 0;
      end else if (bus.busy === 1'b1) begin
        bcnt++;
      end else if (bcnt > 0) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got HI=0x%08h LO=0x%08h expected no result",
                   bus.HI, bus.LO);
        end else begin
          e = sb.pop_front();
          check({e.name, "_hi"}, bus.HI, e.hi);
          check({e.name, "_lo"}, bus.LO, e.lo);
          check({e.name, "_busy_cycles"}, 32'(bcnt), 32'(e.n));
        end
        bcnt = 0;
      end
    end
  end

  // Called at a negedge; request is taken at the following posedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A1    = a;
    bus.A2    = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL busy_timeout: got busy still high after %0d cycles expected low", k);
    end
  endtask

  // Issue a mult/div, check HI/LO hold and busy rises, then queue the expected result.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
    issue(op, a, b);
    check({name, "_busy_rise"}, {31'b0, bus.busy}, 32'd1);
    check({name, "_hold_hi"}, bus.HI, m_hi);
    check({name, "_hold_lo"}, bus.LO, m_lo);
    sb.push_back('{hi: hi, lo: lo, n: (op < 3'd2) ? MultN : DivN, name: name});
    m_hi = hi;
    m_lo = lo;
    wait_idle();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] old_hi;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.A1    = '0;
    bus.A2    = '0;
    reset_n   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_hi", bus.HI, 32'd0);
    check("rst_lo", bus.LO, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // mthi then mtlo on consecutive cycles.
    bus.start = 1'b1;
    bus.op    = 3'd4;
    bus.A1    = 32'hDEAD_BEEF;
    @(negedge clk);
    check("mthi_hi", bus.HI, 32'hDEAD_BEEF);
    check("mthi_busy", {31'b0, bus.busy}, 32'd0);
    bus.op = 3'd5;
    bus.A1 = 32'h1234_5678;
    @(negedge clk);
    bus.start = 1'b0;
    check("mtlo_lo", bus.LO, 32'h1234_5678);
    check("mtlo_hi", bus.HI, 32'hDEAD_BEEF);
    check("mtlo_busy", {31'b0, bus.busy}, 32'd0);

    // Reserved op is a no-op.
    issue(3'd6, 32'h5555_5555, 32'h6666_6666);
    check("rsvd_hi", bus.HI, 32'hDEAD_BEEF);
    check("rsvd_lo", bus.LO, 32'h1234_5678);
    check("rsvd_busy", {31'b0, bus.busy}, 32'd0);

    // Reset three cycles into a mult aborts it.
    issue(3'd0, 32'd5, 32'd7);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_hi", bus.HI, 32'd0);
    check("abort_lo", bus.LO, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_hi    = '0;
    m_lo    = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post_abort_hi", bus.HI, 32'd0);
      check("post_abort_lo", bus.LO, 32'd0);
      check("post_abort_busy", {31'b0, bus.busy}, 32'd0);
    end

    run_op("mult_neg2x3",  3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu_fffe3",  3'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div_m7_2",     3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_7_2",     3'd3, 32'd7,         32'd2, 32'd1,         32'd3);
    run_op("div_ovf",      3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("divu_by0",     3'd3, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div_7_m2",     3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_op("div_by0",      3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // Requests while busy are dropped; only the divu lands.
    old_hi = m_hi;
    issue(3'd3, 32'd100, 32'd7);
    sb.push_back('{hi: 32'd2, lo: 32'd14, n: DivN, name: "divu_drop"});
    m_hi = 32'd2;
    m_lo = 32'd14;
    @(negedge clk);
    issue(3'd0, 32'd3, 32'd3);
    issue(3'd4, 32'hAAAA_5555, 32'd0);
    check("drop_mthi_hi", bus.HI, old_hi);
    check("drop_busy", {31'b0, bus.busy}, 32'd1);
    wait_idle();
    // Back-to-back: issued in the first cycle busy is low.
    run_op("multu_b2b", 3'd1, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, beside the ALU.
- Takes the same forwarded operand pair (A1 = rs value, A2 = rt value) and holds results in architectural HI/LO registers.
- The stall controller reads `busy` to freeze the pipeline on mult/div/mfhi/mflo hazards.
- mfhi/mflo read HI/LO directly from this block's outputs.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; qualifies op and operands.
- op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6/7 reserved (no-op).
- A1  input  32  operand rs.
- A2  input  32  operand rt.
- busy  output  1  operation in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert): busy=0, HI=0, LO=0, state=IDLE, counter=0, pending result regs=0. Reset mid-operation aborts the operation; no late HI/LO write follows.
- States: IDLE, RUN.
- IDLE + start + op in {0..3}:
  - Compute the 64-bit result from A1/A2 sampled at that edge.
  - Store it in the pending registers; HI/LO are not yet touched.
  - Load counter = latency; go to RUN; busy=1 from the next cycle.
- IDLE + start + op 4: HI<=A1 at that edge. op 5: LO<=A1 at that edge. No busy.
- IDLE + start + op 6/7: ignored.
- RUN: counter decrements each edge. At the edge where counter hits 1:
  - HI/LO <= pending; busy<=0; state<=IDLE.
  - Start accepted at edge T, HI/LO visible and busy low after edge T+N, where N = MULT_CYCLES or DIV_CYCLES.
  - busy is high for exactly N cycles.
- start while busy=1 (any op, including mthi/mtlo) is ignored. The stall controller must not issue it; the bench checks it is dropped.
- HI/LO hold their value throughout RUN. Reads during RUN return the old values (the stall controller blocks mfhi/mflo).
- mult: signed 32x32 -> 64; HI = [63:32], LO = [31:0]. multu: unsigned.
- div: LO = signed quotient truncated toward zero; HI = remainder with the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- divu: unsigned quotient and remainder.
- Divide by zero (A2 == 0, div or divu): still takes DIV_CYCLES; result is LO = 0xFFFFFFFF, HI = A1. No exception.
- Result computation may be one combinational stage captured at start, or an iterative datapath. Either way it must finish within N cycles and be bit-exact to the rules above.

Test Plan:
- reset_n=0 mid-RUN, 3 cycles after a mult start -> busy=0 and HI=LO=0 immediately. After release, no HI/LO change for 10+ cycles.
- mult A1=0xFFFFFFFE (-2), A2=3, MULT_CYCLES=5:
  - busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - Same operands with multu -> HI=0x00000002, LO=0xFFFFFFFA.
- div A1=0xFFFFFFF9 (-7), A2=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 -> LO=3, HI=1.
- div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. divu 0x1234 / 0 -> LO=0xFFFFFFFF, HI=0x1234.
- mthi A1=0xDEADBEEF then mtlo A1=0x12345678 on consecutive cycles -> HI/LO updated on those edges, busy never asserted.
- start mult while busy from a divu -> mult dropped; only the divu result lands, at cycle T+DIV_CYCLES. Back-to-back start on the cycle busy falls is accepted.
